winner_scan_nxn: RTL
====================

// Module: winner_scan_nxn
// PURPOSE
// - Sequential, parametrised winner detector for an N x N board of 2-bit cells.
// - Cell codes: 00 empty, 01 player 1, 10 player 2, 11 illegal.
// - On start, latches the board, then checks one line per clock: N rows, N columns,
//   main diagonal, anti-diagonal.
// - Reports winner, player, winning line index and draw status.
// - Sits between the board register file and the game-control FSM; replaces the
//   3-cell combinational check.
// PARAMETERS
// - N   3   board side and win length; legal range 3..8
// - L   2*N+2   lines scanned; localparam, not overridable
// - LW  $clog2(2*N+2)   width of the line index; localparam
// PORTS
// - clock     in   1       rising-edge clock
// - reset     in   1       asynchronous, active-low reset
// - start     in   1       scan request; accepted only when busy=0
// - board     in   2*N*N   cell (r,c) at bits [2*(r*N+c)+1 : 2*(r*N+c)]
// - busy      out  1       scan in progress
// - done      out  1       one-cycle pulse; results valid from this cycle
// - winner    out  1       a complete line owned by one player was found
// - who       out  2       01/10 winning player; 00 if winner=0
// - line      out  LW      winning line index; 0 if winner=0
// - draw      out  1       winner=0 and the board has no 00 cell
// - illegal   out  1       at least one 11 cell in the latched board
// - conflict  out  1       both players own at least one full line
// BEHAVIOUR
// - Reset (asynchronous, active-low): state IDLE; all outputs 0; board latch and
//   index cleared.
// - Reset asserted mid-scan abandons the scan; no done pulse is produced.
// - States: IDLE -> SCAN -> IDLE.
// - IDLE:
//   - start=1 at an edge: latch board, idx=0, busy=1.
//   - Clear winner, who, line, draw, illegal and conflict.
//   - Compute illegal from the latched board on that same edge.
// - SCAN, line order: idx 0..N-1 rows; N..2N-1 columns (idx-N); 2N main diagonal
//   (r=c); 2N+1 anti-diagonal (c=N-1-r).
// - Line win rule: all N cells equal AND the cell value is 01 or 10. Lines
//   containing 00 or 11 never win.
// - Line idx is evaluated combinationally; its result is registered at the next
//   edge, so line i is registered at edge i+1 after the start edge.
// - Recording a win: the first winning line in scan order sets winner, who and line.
//   Later wins never overwrite these.
// - Scan end: the edge that registers line L-1 (or the early exit, see
//   CONFIGURATION) sets done=1 and busy=0 and returns to IDLE.
// - draw is valid with done and is set iff winner=0 and no cell is 00. An 11 cell
//   counts as filled.
// - done is high for exactly one cycle. Result outputs hold until the next accepted
//   start.
// - start while busy=1 is ignored; no queuing.
// - start in the done cycle is accepted, since busy=0 there.
// - The board input may change freely during a scan; only the latched copy is used.
// - Fixed full-scan latency: done L edges after the start edge (N=3: 8).
// CONFIGURATION
// - WINSCAN_EARLY_EXIT_EN defined:
//   - The scan ends on the edge that registers the first winning line.
//   - done arrives i+1 edges after start, where i is that line's index.
//   - conflict is tied to 0.
//   - draw is computed as above.
// - WINSCAN_EARLY_EXIT_EN undefined:
//   - All L lines are always scanned, giving fixed latency L.
//   - conflict=1 when lines of both 01 and 10 were found.
//   - winner, who and line still report the first win in scan order.
// TESTING (N=3, cell order r0c0..r2c2 listed LSB-first)
// - Reset mid-scan: assert reset 3 cycles after start -> all outputs 0 immediately;
//   no done pulse; next start performs a normal scan.
// - Row win: board 01,01,01,10,10,00,00,00,00 -> winner=1, who=01, line=0, draw=0.
//   done at edge 8 (edge 1 with EARLY_EXIT).
// - Anti-diagonal win: cells (0,2),(1,1),(2,0)=10, others mixed/empty ->
//   winner=1, who=10, line=7, done at edge 8 in both configurations.
// - Draw: 01,10,01,01,10,10,10,01,01 -> winner=0, who=00, draw=1, illegal=0,
//   done at edge 8.
// - Illegal cell: cell (1,1)=11, rest empty -> illegal=1, winner=0, draw=0.
//   Row of 11,11,11 -> winner=0.
// - Handshake and conflict:
//   - start held high for 20 cycles -> new scans begin only at the edge where done=1.
//   - Board with row 0 all 01 and row 2 all 10, without EARLY_EXIT ->
//     conflict=1, who=01, line=0.

Source files
------------

// File: rtl/winner_scan_nxn_if.sv
// winner_scan_nxn_if
// Groups the request/result signals of the N x N winner scanner.
//   start    : scan request from the game controller
//   board    : 2*N*N packed cells, cell (r,c) at bits [2*(r*N+c)+1 : 2*(r*N+c)]
//   busy     : scan in progress
//   done     : one-cycle pulse, results valid from this cycle
//   winner   : a full line owned by one player was found
//   who      : winning player (01/10), 00 when no winner
//   line     : index of the first winning line in scan order
//   draw     : no winner and no empty cell
//   illegal  : at least one 11 cell in the latched board
//   conflict : both players own at least one full line
// Modports: master = game controller side, slave = scanner side.
interface winner_scan_nxn_if #(
  parameter int N = 3
);
  localparam int LW = $clog2(2*N+2);

  logic              start;
  logic [2*N*N-1:0]  board;
  logic              busy;
  logic              done;
  logic              winner;
  logic [1:0]        who;
  logic [LW-1:0]     line;
  logic              draw;
  logic              illegal;
  logic              conflict;

  modport master (
    output start, board,
    input  busy, done, winner, who, line, draw, illegal, conflict
  );

  modport slave (
    input  start, board,
    output busy, done, winner, who, line, draw, illegal, conflict
  );
endinterface

// File: rtl/winner_scan_nxn.sv
// winner_scan_nxn
// Sequential winner detector for an N x N board of 2-bit cells
// (00 empty, 01 player 1, 10 player 2, 11 illegal). A start request latches
// the board, then one line is checked per clock: N rows, N columns, the main
// diagonal and the anti-diagonal (L = 2N+2 lines in total).
// Ports:
//   clock : rising-edge clock
//   reset : asynchronous, active-low reset
//   bus   : winner_scan_nxn_if.slave (start/board in, results out)
// Optional feature macro: WINSCAN_EARLY_EXIT_EN
//   defined   -> scan stops on the first winning line, conflict tied to 0
//   undefined -> all L lines always scanned, conflict reported
module winner_scan_nxn #(
  parameter int N = 3
) (
  input  logic               clock,
  input  logic               reset,
  winner_scan_nxn_if.slave   bus
);
  localparam int L  = 2*N+2;
  localparam int LW = $clog2(2*N+2);

  typedef enum logic {IDLE, SCAN} state_t;

  state_t            state;
  state_t            state_next;
  logic              accept;
  logic              scan_end;

  logic [2*N*N-1:0]  brd;
  logic [LW-1:0]     idx;
  logic              busy_q;
  logic              done_q;
  logic              winner_q;
  logic [1:0]        who_q;
  logic [LW-1:0]     line_q;
  logic              draw_q;
  logic              illegal_q;
  logic              conflict_q;
  logic              seen1_q;
  logic              seen2_q;

  logic [L-1:0]      lwin;
  logic [1:0]        lval [L];
  logic              line_win;
  logic [1:0]        line_who;
  logic [N*N-1:0]    cell_empty;
  logic [N*N-1:0]    cell_bad;
  logic              has_empty;
  logic              in_illegal;

  // Every line is decoded from the latched board with constant cell
  // coordinates; the scan then just selects the line at idx.
  for (genvar li = 0; li < L; li++) begin : g_line
    logic [1:0]   lc [N];
    logic [N-1:0] eq;
    for (genvar k = 0; k < N; k++) begin : g_cell
      localparam int R = (li < N) ? li : k;
      localparam int C = (li < N)     ? k :
                         (li < 2*N)   ? li - N :
                         (li == 2*N)  ? k : N - 1 - k;
      assign lc[k] = brd[2*(R*N+C) +: 2];
      assign eq[k] = (lc[k] == lc[0]);
    end
    // A line wins only when all cells match and hold a real player code.
    assign lwin[li] = (&eq) && ((lc[0] == 2'b01) || (lc[0] == 2'b10));
    assign lval[li] = lc[0];
  end

  // Empty cells come from the latched board (draw); illegal cells come from
  // the incoming board because illegal is captured on the start edge itself.
  for (genvar ci = 0; ci < N*N; ci++) begin : g_cellflags
    assign cell_empty[ci] = (brd[2*ci +: 2] == 2'b00);
    assign cell_bad[ci]   = (bus.board[2*ci +: 2] == 2'b11);
  end

  assign has_empty  = |cell_empty;
  assign in_illegal = |cell_bad;
  assign line_win   = lwin[idx];
  assign line_who   = lval[idx];

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: a start is only seen in IDLE, so requests while busy
  // are dropped; the scan ends on the last line or, with early exit, on
  // the first winning line.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    scan_end   = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          accept     = 1'b1;
          state_next = SCAN;
        end
      end
      SCAN: begin
`ifdef WINSCAN_EARLY_EXIT_EN
        if ((idx == LW'(L-1)) || line_win) begin
`else
        if (idx == LW'(L-1)) begin
`endif
          scan_end   = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Datapath: board latch, line index and result registers. Only the first
  // win in scan order is recorded; the per-player seen flags feed conflict.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      brd        <= '0;
      idx        <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      winner_q   <= 1'b0;
      who_q      <= 2'b00;
      line_q     <= '0;
      draw_q     <= 1'b0;
      illegal_q  <= 1'b0;
      conflict_q <= 1'b0;
      seen1_q    <= 1'b0;
      seen2_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (accept) begin
        brd        <= bus.board;
        idx        <= '0;
        busy_q     <= 1'b1;
        winner_q   <= 1'b0;
        who_q      <= 2'b00;
        line_q     <= '0;
        draw_q     <= 1'b0;
        illegal_q  <= in_illegal;
        conflict_q <= 1'b0;
        seen1_q    <= 1'b0;
        seen2_q    <= 1'b0;
      end else if (state == SCAN) begin
        idx <= idx + LW'(1);
        if (line_win && !winner_q) begin
          winner_q <= 1'b1;
          who_q    <= line_who;
          line_q   <= idx;
        end
        if (line_win && (line_who == 2'b01)) seen1_q <= 1'b1;
        if (line_win && (line_who == 2'b10)) seen2_q <= 1'b1;
        if (scan_end) begin
          busy_q <= 1'b0;
          done_q <= 1'b1;
          draw_q <= !(winner_q || line_win) && !has_empty;
`ifdef WINSCAN_EARLY_EXIT_EN
          conflict_q <= 1'b0;
`else
          conflict_q <= (seen1_q || (line_win && (line_who == 2'b01))) &&
                        (seen2_q || (line_win && (line_who == 2'b10)));
`endif
        end
      end
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.winner   = winner_q;
  assign bus.who      = who_q;
  assign bus.line     = line_q;
  assign bus.draw     = draw_q;
  assign bus.illegal  = illegal_q;
  assign bus.conflict = conflict_q;
endmodule
